// File: rtl/matrix_result_reducer.sv
// matrix_result_reducer: sums one result matrix streamed over valid/ready,
// counts the cycles spent consuming it, and holds the results for display.
module matrix_result_reducer #(
    parameter int ELEM_W    = 16,
    parameter int SUM_W     = 24,
    parameter int CNT_W     = 24,
    parameter int NUM_ELEMS = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ELEM_W-1:0] elem_data,
    input  logic              elem_valid,
    input  logic              elem_last,
    output logic              elem_ready,
    output logic [SUM_W-1:0]  result_sum,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              framing_err
);

    localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              at_last;
    logic              launch;
    logic [SUM_W:0]    sum_ext;

    // Handshake and control decodes; ready depends on state only.
    assign elem_ready = (state == S_RUN);
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);
    assign accept     = elem_valid && (state == S_RUN);
    assign at_last    = (idx == LAST_IDX);
    assign launch     = start && (state != S_RUN);
    // One extra bit on the adder exposes the carry out of the sum.
    assign sum_ext    = {1'b0, result_sum} + (SUM_W+1)'(elem_data);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state: run ends on the accept at the final index, never on elem_last.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && at_last) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Accumulator, cycle counter, element index and sticky error flags.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            result_sum  <= '0;
            cycle_count <= '0;
            idx         <= '0;
            overflow    <= 1'b0;
            framing_err <= 1'b0;
        end else if (launch) begin
            result_sum  <= '0;
            cycle_count <= '0;
            idx         <= '0;
            overflow    <= 1'b0;
            framing_err <= 1'b0;
        end else if (state == S_RUN) begin
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            if (accept) begin
                result_sum <= sum_ext[SUM_W-1:0];
                if (sum_ext[SUM_W])         overflow    <= 1'b1;
                if (elem_last != at_last)   framing_err <= 1'b1;
                idx <= at_last ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_result_reducer.sv
// tb_matrix_result_reducer: randomized runs against a per-matrix reference
// model; a second instance with a 19-bit sum exercises wrap/overflow.
module tb_matrix_result_reducer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] elem_data;
    logic        elem_valid;
    logic        elem_last;

    logic        ready_a, busy_a, done_a, ovf_a, ferr_a;
    logic [23:0] sum_a, cnt_a;
    logic        ready_b, busy_b, done_b, ovf_b, ferr_b;
    logic [18:0] sum_b;
    logic [23:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matrix_result_reducer u_dut (
        .CLOCK_50(clk), .reset_n(rst_n), .start(start),
        .elem_data(elem_data), .elem_valid(elem_valid), .elem_last(elem_last),
        .elem_ready(ready_a), .result_sum(sum_a), .cycle_count(cnt_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .framing_err(ferr_a)
    );

    matrix_result_reducer #(.SUM_W(19)) u_dut19 (
        .CLOCK_50(clk), .reset_n(rst_n), .start(start),
        .elem_data(elem_data), .elem_valid(elem_valid), .elem_last(elem_last),
        .elem_ready(ready_b), .result_sum(sum_b), .cycle_count(cnt_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .framing_err(ferr_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, ready_a, 0);
        chk({tag, "_sum"},   sum_a,   0);
        chk({tag, "_cnt"},   cnt_a,   0);
        chk({tag, "_busy"},  busy_a,  0);
        chk({tag, "_done"},  done_a,  0);
        chk({tag, "_ovf"},   ovf_a,   0);
        chk({tag, "_ferr"},  ferr_a,  0);
        chk({tag, "_sum19"}, sum_b,   0);
        chk({tag, "_ovf19"}, ovf_b,   0);
        chk({tag, "_rdy19"}, ready_b, 0);
    endtask

    // One matrix: model tracks the true (unbounded) sum of the first 16
    // accepted elements; wrapped sums and overflow follow from it directly.
    // mode: 0 ramp 1..16, 1 gapped 5s, 2 all 0xFFFF, 3 bad framing,
    //       4 random valid/data, 5 all 2s.
    task automatic run(input int mode, input int abort_at, input bit poke_start);
        int              acc;
        int              cyc;
        longint unsigned tsum;
        bit              ferr;
        bit              v;
        bit              l;
        logic [15:0]     d;
        @(negedge clk);
        start      = 1'b1;
        elem_valid = 1'($urandom);
        elem_data  = 16'($urandom);
        elem_last  = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        chk("start_busy",  busy_a, 1);
        chk("start_done",  done_a, 0);
        chk("start_sum",   sum_a,  0);
        chk("start_cnt",   cnt_a,  0);
        chk("start_ovf",   ovf_a,  0);
        chk("start_ferr",  ferr_a, 0);
        chk("start_sum19", sum_b,  0);
        chk("start_ovf19", ovf_b,  0);
        acc = 0; cyc = 0; tsum = 0; ferr = 1'b0;
        while (acc < 16 && cyc < 200) begin
            case (mode)
                1:       v = (cyc % 2 == 0);
                4:       v = ($urandom_range(0, 2) != 0);
                default: v = 1'b1;
            endcase
            if (!v) d = 16'($urandom);
            else case (mode)
                0:       d = 16'(acc + 1);
                1:       d = 16'd5;
                2:       d = 16'hFFFF;
                5:       d = 16'd2;
                default: d = 16'($urandom);
            endcase
            if (!v)            l = 1'($urandom);
            else if (mode == 3) l = (acc == 4);
            else               l = (acc == 15);
            elem_valid = v;
            elem_data  = d;
            elem_last  = l;
            start      = poke_start && (acc == 4);
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (v) begin
                if (l != (acc == 15)) ferr = 1'b1;
                tsum += d;
                acc++;
            end
            chk("run_cnt",   cnt_a, 32'(cyc));
            chk("run_sum",   sum_a, 32'(tsum & 64'hFFFFFF));
            chk("run_sum19", sum_b, 32'(tsum & 64'h7FFFF));
            chk("run_ovf",   ovf_a, 32'(tsum >= 64'h1000000));
            chk("run_ovf19", ovf_b, 32'(tsum >= 64'h80000));
            chk("run_ferr",  ferr_a, 32'(ferr));
            chk("run_busy",  busy_a, 32'(acc < 16));
            chk("run_ready", ready_a, 32'(acc < 16));
            chk("run_done",  done_a, 32'(acc == 16));
            if (abort_at != 0 && acc == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("midrun_rst");
                @(negedge clk);
                rst_n = 1'b1;
                elem_valid = 1'b0;
                return;
            end
        end
        if (acc < 16) chk("run_timeout", 32'(acc), 16);
        elem_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; elem_valid = 1'b0; elem_last = 1'b0; elem_data = '0;
        // Reset with random inputs, including start: reset must win.
        repeat (3) begin
            @(negedge clk);
            start      = 1'($urandom);
            elem_valid = 1'($urandom);
            elem_last  = 1'($urandom);
            elem_data  = 16'($urandom);
        end
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        // Valids in IDLE are ignored.
        repeat (3) begin
            elem_valid = 1'b1;
            elem_data  = 16'($urandom);
            @(negedge clk);
        end
        chk_zero("idle_hold");
        elem_valid = 1'b0;

        run(0, 0, 1'b0);
        chk("b2b_sum", sum_a, 136);
        chk("b2b_cnt", cnt_a, 16);
        // Valids in DONE are ignored and results hold.
        repeat (3) begin
            elem_valid = 1'b1;
            elem_data  = 16'($urandom);
            @(negedge clk);
        end
        elem_valid = 1'b0;
        chk("done_hold_sum",  sum_a,  136);
        chk("done_hold_cnt",  cnt_a,  16);
        chk("done_hold_done", done_a, 1);

        run(1, 0, 1'b0);
        chk("gap_sum", sum_a, 80);
        chk("gap_cnt", cnt_a, 31);

        run(2, 0, 1'b0);
        chk("ovf_sum19", sum_b, 32'h7FFF0);
        chk("ovf_flag19", ovf_b, 1);

        run(3, 0, 1'b0);
        chk("frame_err", ferr_a, 1);

        run(5, 8, 1'b1);
        run(5, 0, 1'b0);
        chk("post_rst_sum", sum_a, 32);
        chk("post_rst_cnt", cnt_a, 16);

        repeat (4) run(4, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
